// File: rtl/max7219_pkg.sv
// Shared MAX7219 constants: register addresses, transmitter FSM states and
// the power-up init command list.
package max7219_pkg;

    localparam logic [3:0] ADDR_NOOP       = 4'h0;
    localparam logic [3:0] ADDR_DIGIT0     = 4'h1;
    localparam logic [3:0] ADDR_DIGIT1     = 4'h2;
    localparam logic [3:0] ADDR_DIGIT2     = 4'h3;
    localparam logic [3:0] ADDR_DIGIT3     = 4'h4;
    localparam logic [3:0] ADDR_DIGIT4     = 4'h5;
    localparam logic [3:0] ADDR_DIGIT5     = 4'h6;
    localparam logic [3:0] ADDR_DIGIT6     = 4'h7;
    localparam logic [3:0] ADDR_DIGIT7     = 4'h8;
    localparam logic [3:0] ADDR_DECODE     = 4'h9;
    localparam logic [3:0] ADDR_INTENSITY  = 4'hA;
    localparam logic [3:0] ADDR_SCAN_LIMIT = 4'hB;
    localparam logic [3:0] ADDR_SHUTDOWN   = 4'hC;
    localparam logic [3:0] ADDR_TEST       = 4'hF;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_SHIFT_LO,
        ST_SHIFT_HI,
        ST_LATCH
    } state_t;

    typedef struct packed {
        logic [3:0] addr;
        logic [7:0] data;
    } init_cmd_t;

    localparam int unsigned INIT_LEN = 5;

    // Broadcast to every device in this order after reset
    localparam init_cmd_t INIT_SEQ [INIT_LEN] = '{
        '{addr: ADDR_SHUTDOWN,   data: 8'h01},
        '{addr: ADDR_SCAN_LIMIT, data: 8'h07},
        '{addr: ADDR_DECODE,     data: 8'h00},
        '{addr: ADDR_INTENSITY,  data: 8'h08},
        '{addr: ADDR_TEST,       data: 8'h00}
    };

endpackage

// File: rtl/max7219_tx_prescaler.sv
// Phase timer: one-cycle tick after G_CLK_DIV cycles in the same FSM state.
module max7219_tx_prescaler #(
    parameter int unsigned G_CLK_DIV = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    output logic tick
);

    localparam int unsigned CW = $clog2(G_CLK_DIV + 1);

    logic [CW-1:0] cnt;

    assign tick = (cnt == CW'(G_CLK_DIV - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (clr || tick) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CW'(1);
        end
    end

endmodule

// File: rtl/max7219_daisy_tx.sv
// Daisy-chain MAX7219 transmitter: shifts one 16-bit word per device, farthest
// first, then strobes LOAD. Define MAX7219_DAISY_TX_INIT_EN for the init sequencer.
module max7219_daisy_tx
    import max7219_pkg::*;
#(
    parameter int unsigned G_NB_MATRIX = 8,
    parameter int unsigned G_CLK_DIV   = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_start,
    input  logic [4*G_NB_MATRIX-1:0] i_addr,
    input  logic [8*G_NB_MATRIX-1:0] i_data,
    output logic                     o_busy,
    output logic                     o_done,
    output logic                     o_max7219_clk,
    output logic                     o_max7219_din,
    output logic                     o_max7219_load
);

    localparam int unsigned NB_BITS = 16 * G_NB_MATRIX;
    localparam int unsigned BW      = $clog2(NB_BITS + 1);

    state_t             state, next_state;
    logic               tick, clr;
    logic [NB_BITS-1:0] sreg, load_word;
    logic [BW-1:0]      bit_cnt;
    logic               start_go, last_bit, tx_end, shift_step;
    logic               hold_busy, done_ok;
    logic               busy_d, done_d, clk_d, din_d, load_d;

    assign last_bit   = (bit_cnt == BW'(NB_BITS - 1));
    assign tx_end     = (state == ST_LATCH) && tick;
    assign shift_step = (state == ST_SHIFT_HI) && tick && !last_bit;
    assign clr        = (next_state != state) || (state == ST_IDLE);

    max7219_tx_prescaler #(.G_CLK_DIV(G_CLK_DIV)) u_prescaler (
        .clk  (clk),
        .rst  (rst),
        .clr  (clr),
        .tick (tick)
    );

`ifdef MAX7219_DAISY_TX_INIT_EN
    logic       init_run;
    logic [2:0] init_idx;
    logic       init_last;

    assign init_last = (init_idx == 3'(INIT_LEN - 1));
    assign start_go  = (state == ST_IDLE) && (init_run || i_start);
    assign hold_busy = init_run && !(tx_end && init_last);
    assign done_ok   = !init_run || init_last;

    // Walks the init list, one entry per completed transaction
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            init_run <= 1'b1;
            init_idx <= '0;
        end else if (tx_end && init_run) begin
            if (init_last) begin
                init_run <= 1'b0;
            end else begin
                init_idx <= init_idx + 3'(1);
            end
        end
    end

    always_comb begin
        load_word = '0;
        for (int i = 0; i < G_NB_MATRIX; i++) begin
            if (init_run) begin
                load_word[16*i +: 16] = {4'h0, INIT_SEQ[init_idx].addr, INIT_SEQ[init_idx].data};
            end else begin
                load_word[16*i +: 16] = {4'h0, i_addr[4*i +: 4], i_data[8*i +: 8]};
            end
        end
    end
`else
    assign start_go  = (state == ST_IDLE) && i_start;
    assign hold_busy = 1'b0;
    assign done_ok   = 1'b1;

    // Matrix N-1 lands in the top word so it leaves first
    always_comb begin
        load_word = '0;
        for (int i = 0; i < G_NB_MATRIX; i++) begin
            load_word[16*i +: 16] = {4'h0, i_addr[4*i +: 4], i_data[8*i +: 8]};
        end
    end
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state          <= ST_IDLE;
            o_busy         <= 1'b0;
            o_done         <= 1'b0;
            o_max7219_clk  <= 1'b0;
            o_max7219_din  <= 1'b0;
            o_max7219_load <= 1'b1;
        end else begin
            state          <= next_state;
            o_busy         <= busy_d;
            o_done         <= done_d;
            o_max7219_clk  <= clk_d;
            o_max7219_din  <= din_d;
            o_max7219_load <= load_d;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE:     if (start_go) next_state = ST_SETUP;
            ST_SETUP:    if (tick)     next_state = ST_SHIFT_LO;
            ST_SHIFT_LO: if (tick)     next_state = ST_SHIFT_HI;
            ST_SHIFT_HI: if (tick)     next_state = last_bit ? ST_LATCH : ST_SHIFT_LO;
            ST_LATCH:    if (tick)     next_state = ST_IDLE;
            default:                   next_state = ST_IDLE;
        endcase
    end

    // Pin values for the upcoming state; din only moves as clk falls or at start
    always_comb begin
        busy_d = (next_state != ST_IDLE) || hold_busy;
        done_d = tx_end && done_ok;
        clk_d  = (next_state == ST_SHIFT_HI);
        load_d = (next_state == ST_IDLE) || (next_state == ST_LATCH);
        din_d  = o_max7219_din;
        if (start_go) begin
            din_d = load_word[NB_BITS-1];
        end else if (shift_step) begin
            din_d = sreg[NB_BITS-2];
        end else if (load_d) begin
            din_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sreg    <= '0;
            bit_cnt <= '0;
        end else if (start_go) begin
            sreg    <= load_word;
            bit_cnt <= '0;
        end else if ((state == ST_SHIFT_HI) && tick) begin
            bit_cnt <= bit_cnt + BW'(1);
            if (!last_bit) begin
                sreg <= {sreg[NB_BITS-2:0], 1'b0};
            end
        end
    end

endmodule

// File: tb/tb_max7219_daisy_tx.sv
// Bench for max7219_daisy_tx: 2-device/div-2 instance for the main vectors,
// 1-device/div-1 instance for the tightest timing.
module tb_max7219_daisy_tx;

    localparam int BUSY_A = 132;
    localparam int BUSY_B = 34;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start_a, busy_a, done_a, mclk_a, din_a, load_a;
    logic [7:0]  addr_a;
    logic [15:0] data_a;
    logic        start_b, busy_b, done_b, mclk_b, din_b, load_b;
    logic [3:0]  addr_b;
    logic [7:0]  data_b;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [7:0]  addr;
        logic [15:0] data;
        int          ign1;
        int          ign2;
        int          chg_at;
        logic [15:0] chg_val;
        logic [31:0] exp_stream;
    } vec_t;

    max7219_daisy_tx #(.G_NB_MATRIX(2), .G_CLK_DIV(2)) dut_a (
        .clk(clk), .rst(rst), .i_start(start_a), .i_addr(addr_a), .i_data(data_a),
        .o_busy(busy_a), .o_done(done_a), .o_max7219_clk(mclk_a),
        .o_max7219_din(din_a), .o_max7219_load(load_a)
    );

    max7219_daisy_tx #(.G_NB_MATRIX(1), .G_CLK_DIV(1)) dut_b (
        .clk(clk), .rst(rst), .i_start(start_b), .i_addr(addr_b), .i_data(data_b),
        .o_busy(busy_b), .o_done(done_b), .o_max7219_clk(mclk_b),
        .o_max7219_din(din_b), .o_max7219_load(load_b)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // One transaction on dut_a, sampled at negedges; returns at first non-busy cycle
    task automatic tx_a(input vec_t v, output logic [31:0] stream, output int nbits,
                        output int ncyc, output int glitch, output int loads, output int dones);
        logic pc, pd, pl;
        stream = '0; nbits = 0; ncyc = 0; glitch = 0; loads = 0; dones = 0;
        pc = 1'b0; pd = 1'b0; pl = 1'b0;
        addr_a = v.addr; data_a = v.data; start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        while (busy_a === 1'b1 && ncyc < 400) begin
            ncyc++;
            if (mclk_a && !pc) begin
                stream = {stream[30:0], din_a};
                nbits++;
            end
            if (mclk_a && din_a !== pd) glitch++;
            if (load_a && !pl) loads++;
            if (done_a) dones++;
            start_a = (ncyc == v.ign1) || (ncyc == v.ign2);
            if (ncyc == v.chg_at) data_a = v.chg_val;
            pc = mclk_a; pd = din_a; pl = load_a;
            @(negedge clk);
        end
        start_a = 1'b0;
    endtask

`ifdef MAX7219_DAISY_TX_INIT_EN
    task automatic init_check();
        logic [31:0] s;
        logic [31:0] got [5];
        logic [31:0] exp [5];
        int nc, loads, dones;
        logic pc, pl;
        exp[0] = 32'h0C01_0C01; exp[1] = 32'h0B07_0B07; exp[2] = 32'h0900_0900;
        exp[3] = 32'h0A08_0A08; exp[4] = 32'h0F00_0F00;
        for (int k = 0; k < 5; k++) got[k] = '0;
        nc = 0;
        while (busy_a !== 1'b1 && nc < 10) begin
            nc++;
            @(negedge clk);
        end
        nc = 0; s = '0; loads = 0; dones = 0; pc = 1'b0; pl = 1'b0;
        addr_a = 8'h33; data_a = 16'h5555;
        while (busy_a === 1'b1 && nc < 2000) begin
            nc++;
            start_a = (nc == 20) || (nc == 133);
            if (mclk_a && !pc) s = {s[30:0], din_a};
            if (load_a && !pl) begin
                if (loads < 5) got[loads] = s;
                loads++;
            end
            if (done_a) dones++;
            pc = mclk_a; pl = load_a;
            @(negedge clk);
        end
        start_a = 1'b0;
        check("init busy length", 32'(nc), 32'(5 * BUSY_A + 4));
        check("init load count", 32'(loads), 32'd5);
        check("init done inside busy", 32'(dones), 32'd0);
        check("init done pulse", {31'b0, done_a}, 32'd1);
        for (int k = 0; k < 5; k++) check($sformatf("init word %0d", k), got[k], exp[k]);
        @(negedge clk);
        check("init after done busy", {31'b0, busy_a}, 32'd0);
        check("init after done done", {31'b0, done_a}, 32'd0);
    endtask
`endif

    initial begin
        vec_t        vt [5];
        logic [31:0] s;
        int          nb, nc, gl, lr, dn;
        logic        pc, pd;

        vt[0] = '{8'h11, 16'h3C81, -1,  -1, -1, 16'h0000, 32'h013C_0181};
        vt[1] = '{8'h11, 16'h3C81,  1,  50, -1, 16'h0000, 32'h013C_0181};
        vt[2] = '{8'h2B, 16'hA507, -1,  -1, 10, 16'hFFFF, 32'h02A5_0B07};
        vt[3] = '{8'hF0, 16'h00FF, -1,  -1, -1, 16'h0000, 32'h0F00_00FF};
        vt[4] = '{8'h5A, 16'h1234, 131, -1, -1, 16'h0000, 32'h0512_0A34};

        start_a = 1'b0; addr_a = '0; data_a = '0;
        start_b = 1'b0; addr_b = '0; data_b = '0;

        repeat (3) @(negedge clk);
        check("reset a busy", {31'b0, busy_a}, 32'd0);
        check("reset a done", {31'b0, done_a}, 32'd0);
        check("reset a clk",  {31'b0, mclk_a}, 32'd0);
        check("reset a din",  {31'b0, din_a},  32'd0);
        check("reset a load", {31'b0, load_a}, 32'd1);
        check("reset b load", {31'b0, load_b}, 32'd1);
        rst = 1'b0;
        @(negedge clk);

`ifdef MAX7219_DAISY_TX_INIT_EN
        init_check();
`endif

        for (int i = 0; i < 5; i++) begin
            tx_a(vt[i], s, nb, nc, gl, lr, dn);
            check($sformatf("v%0d stream", i), s, vt[i].exp_stream);
            check($sformatf("v%0d bits", i), 32'(nb), 32'd32);
            check($sformatf("v%0d busy cycles", i), 32'(nc), 32'(BUSY_A));
            check($sformatf("v%0d din glitch", i), 32'(gl), 32'd0);
            check($sformatf("v%0d load rises", i), 32'(lr), 32'd1);
            check($sformatf("v%0d done in busy", i), 32'(dn), 32'd0);
            check($sformatf("v%0d done pulse", i), {31'b0, done_a}, 32'd1);
            @(negedge clk);
            check($sformatf("v%0d idle busy", i), {31'b0, busy_a}, 32'd0);
            check($sformatf("v%0d idle done", i), {31'b0, done_a}, 32'd0);
        end

        // i_start held high straight through o_done
        addr_a = 8'h11; data_a = 16'h3C81; start_a = 1'b1;
        @(negedge clk);
        nc = 0;
        while (busy_a === 1'b1 && nc < 400) begin
            nc++;
            @(negedge clk);
        end
        check("b2b first busy", 32'(nc), 32'(BUSY_A));
        check("b2b done", {31'b0, done_a}, 32'd1);
        @(negedge clk);
        start_a = 1'b0;
        check("b2b restart busy", {31'b0, busy_a}, 32'd1);
        check("b2b restart done", {31'b0, done_a}, 32'd0);
        nc = 0;
        while (busy_a === 1'b1 && nc < 400) begin
            nc++;
            @(negedge clk);
        end
        check("b2b second busy", 32'(nc), 32'(BUSY_A));
        check("b2b second done", {31'b0, done_a}, 32'd1);
        @(negedge clk);

        // Asynchronous reset at busy cycle 40, din is 1 at that point
        addr_a = 8'h11; data_a = 16'hFF81; start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        repeat (39) @(negedge clk);
        check("midrst pre busy", {31'b0, busy_a}, 32'd1);
        check("midrst pre din", {31'b0, din_a}, 32'd1);
        rst = 1'b1;
        #1;
        check("midrst clk",  {31'b0, mclk_a}, 32'd0);
        check("midrst din",  {31'b0, din_a},  32'd0);
        check("midrst load", {31'b0, load_a}, 32'd1);
        check("midrst busy", {31'b0, busy_a}, 32'd0);
        check("midrst done", {31'b0, done_a}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
`ifdef MAX7219_DAISY_TX_INIT_EN
        init_check();
`endif
        tx_a(vt[0], s, nb, nc, gl, lr, dn);
        check("postrst stream", s, vt[0].exp_stream);
        check("postrst busy cycles", 32'(nc), 32'(BUSY_A));
        check("postrst done", {31'b0, done_a}, 32'd1);
        @(negedge clk);

        // Single device, divider 1
        addr_b = 4'hA; data_b = 8'h0F; start_b = 1'b1;
        @(negedge clk);
        start_b = 1'b0;
        nc = 0; nb = 0; gl = 0; s = '0; pc = 1'b0; pd = 1'b0;
        while (busy_b === 1'b1 && nc < 200) begin
            nc++;
            if (mclk_b && !pc) begin
                s = {s[30:0], din_b};
                nb++;
            end
            if (mclk_b && din_b !== pd) gl++;
            pc = mclk_b; pd = din_b;
            @(negedge clk);
        end
        check("b stream", s, 32'h0000_0A0F);
        check("b rising edges", 32'(nb), 32'd16);
        check("b busy cycles", 32'(nc), 32'(BUSY_B));
        check("b din glitch", 32'(gl), 32'd0);
        check("b done", {31'b0, done_b}, 32'd1);
        @(negedge clk);
        check("b idle done", {31'b0, done_b}, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/max7219_daisy_tx.md
# max7219_daisy_tx

Serial transmitter that drives a daisy chain of G_NB_MATRIX MAX7219 LED-matrix controllers over the three-wire CLK/DIN/LOAD interface. It sits between display logic and the chain pins. It accepts one 16-bit command word per device per transaction and shifts the words out MSB first, farthest device first. It then pulses LOAD so that every device latches its word simultaneously. The max7219_checker chain is its natural bench load.

## Interface
- G_NB_MATRIX, 8, number of chained devices (≥1)
- G_CLK_DIV, 4, clk cycles per MAX7219 CLK half-period (≥1)

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- i_start  in  1  transaction request, sampled only when idle
- i_addr  in  4*G_NB_MATRIX  register address; [4*i+:4] targets matrix i (matrix 0 nearest the driver)
- i_data  in  8*G_NB_MATRIX  register data; [8*i+:8] for matrix i
- o_busy  out  1  transaction in progress
- o_done  out  1  one-cycle pulse at end of transaction
- o_max7219_clk  out  1  serial clock
- o_max7219_din  out  1  serial data
- o_max7219_load  out  1  latch strobe (rising edge latches)

## Operation
- Word for matrix i is {4'h0, i_addr[4*i+:4], i_data[8*i+:8]}, sent MSB first.
- Send order: matrix G_NB_MATRIX-1 first, matrix 0 last; 16*G_NB_MATRIX bits in total.
- i_addr and i_data are captured into an internal shift register on the accepted start. Input changes while busy are ignored.
- FSM states:
  - IDLE: clk=0, din=0, load=1. i_start=1 moves to SETUP.
  - SETUP: load=0, din=first bit, G_CLK_DIV cycles, then to SHIFT_LO.
  - SHIFT_LO: clk=0, G_CLK_DIV cycles, then to SHIFT_HI.
  - SHIFT_HI: clk=1, G_CLK_DIV cycles. The bit counter increments. If the bit count reaches 16*N, go to LATCH; otherwise present the next din and go to SHIFT_LO.
  - LATCH: clk=0, load=1 (rising edge), G_CLK_DIV cycles, then back to IDLE with o_done=1.
- i_start while busy is ignored; there is no queueing.
- i_start in the same cycle as o_done is accepted, because the block is already IDLE.
- din changes only while clk=0. It is stable for G_CLK_DIV cycles before and after each clk rising edge.

## Timing
- Reset values: o_busy=0, o_done=0, o_max7219_clk=0, o_max7219_din=0, o_max7219_load=1, FSM=IDLE, counters=0.
- Timing reference: i_start is sampled at edge T.
- From T+1, o_busy=1 and load=0.
- o_busy stays high for exactly G_CLK_DIV*(32*G_NB_MATRIX+2) cycles.
- o_done=1 for one cycle, coincident with the first o_busy=0 cycle.
- Bit b (0-based) rises clk at cycle T+1+G_CLK_DIV*(2+2b).
- Reset asserted mid-transaction forces all outputs to their reset values asynchronously. The load rise this causes may latch partial data in the devices; this is accepted. The bench checks only the block outputs in this case.
- Divider counter width: $clog2(G_CLK_DIV+1). Bit counter width: $clog2(16*G_NB_MATRIX+1).

## Configuration
- MAX7219_DAISY_TX_INIT_EN defined: an init sequencer is compiled in. After reset release it issues five broadcast transactions, in this order:
  - shutdown = 0x01 (addr 0xC)
  - scan-limit = 0x07 (addr 0xB)
  - decode = 0x00 (addr 0x9)
  - intensity = 0x08 (addr 0xA)
  - display-test = 0x00 (addr 0xF)
- During the init sequence o_busy is held 1 continuously and i_start is ignored. o_done pulses once, after the last init transaction only.
- Macro undefined: no sequencer; the block is IDLE immediately after reset.

## Structure
- Shared package max7219_pkg holds:
  - address constants: NOOP=0x0, DIGIT0..7=0x1..0x8, DECODE=0x9, INTENSITY=0xA, SCAN_LIMIT=0xB, SHUTDOWN=0xC, TEST=0xF
  - the FSM state enum
  - the init-sequence constant array
- Sub-module max7219_tx_prescaler: G_CLK_DIV counter producing a one-cycle phase tick, cleared on each state change.

## Test plan
Use G_NB_MATRIX=2 and G_CLK_DIV=2 unless stated otherwise.
1. i_addr=8'h11, i_data=16'h3C81 → din stream 0x013C then 0x0181. In a checker chain, matrix0 DIGIT0=0x81 and matrix1 DIGIT0=0x3C. o_busy lasts 132 cycles, followed by a single o_done.
2. Second i_start pulsed at busy cycles 1 and 50 → ignored, exactly one transaction on the pins. i_start held high through o_done → back-to-back transaction, with o_busy low only on the o_done cycle.
3. i_data changed at busy cycle 10 → the transmitted stream still carries the value captured at start.
4. rst asserted at busy cycle 40 → outputs immediately clk=0, din=0, load=1, busy=0. A new start after release → a clean 132-cycle transaction.
5. G_CLK_DIV=1, G_NB_MATRIX=1, addr 0xA, data 0x0F → 16 clk rising edges. din is stable one cycle on each side of every rising edge. busy lasts 34 cycles.
6. With MAX7219_DAISY_TX_INIT_EN → after reset, 5 transactions carrying the listed address/data pairs to both matrices. A start during init is ignored. o_done pulses exactly once.
